// File: rtl/alu_pkg.sv
// Shared opcodes, widths and the FuncOp decode used by the ALU operand stage.
package alu_pkg;
    localparam int WORD_W = 24;
    localparam int REG_AW = 4;

    localparam logic [2:0] FUNC_ADD = 3'd0;
    localparam logic [2:0] FUNC_SUB = 3'd1;
    localparam logic [2:0] FUNC_AND = 3'd2;
    localparam logic [2:0] FUNC_OR  = 3'd3;
    localparam logic [2:0] FUNC_NOR = 3'd4;
    localparam logic [2:0] FUNC_SLT = 3'd5;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic       ainv;
        logic       bneg;
        logic [2:0] op;
        logic       legal;
    } dec_t;

    typedef struct packed {
        word_t             a;
        word_t             b;
        logic              ainv;
        logic              bneg;
        logic [2:0]        op;
        logic [REG_AW-1:0] rd;
    } out_t;

    // NOR is built as ~A & ~B, so it reuses the AND path with both inverts.
    function automatic dec_t decode(input logic [2:0] f);
        dec_t d;
        d = '{ainv: 1'b0, bneg: 1'b0, op: ALU_AND, legal: 1'b1};
        case (f)
            FUNC_ADD: d.op = ALU_ADD;
            FUNC_SUB: begin d.bneg = 1'b1; d.op = ALU_ADD; end
            FUNC_AND: d.op = ALU_AND;
            FUNC_OR:  d.op = ALU_OR;
            FUNC_NOR: begin d.ainv = 1'b1; d.bneg = 1'b1; d.op = ALU_AND; end
            FUNC_SLT: begin d.bneg = 1'b1; d.op = ALU_SLT; end
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/reg_file_16x24.sv
// Register file: synchronous write, two asynchronous reads, R0 hardwired to zero.
module reg_file_16x24
    import alu_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  word_t             wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output word_t             rdata_a,
    output word_t             rdata_b
);
    logic [NREGS-1:0][WORD_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: decode, register read with Ex/WB bypass,
// and a single registered output slot on a valid/ready handshake.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int IMM_W = 12
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        FuncOp,
    input  logic [REG_AW-1:0] Rs,
    input  logic [REG_AW-1:0] Rt,
    input  logic [REG_AW-1:0] Rd,
    input  logic [IMM_W-1:0]  Imm,
    input  logic              UseImm,
    output logic              OutValid,
    input  logic              OutReady,
    output word_t             A,
    output word_t             B,
    output logic              AInvert,
    output logic              BNegate,
    output logic [2:0]        ALUOp,
    output logic [REG_AW-1:0] OutRd,
    input  word_t             ExResult,
    input  logic              WbEn,
    input  logic [REG_AW-1:0] WbAddr,
    input  word_t             WbData,
    output logic              IllegalOp
);
    logic  out_valid, illegal_q, in_ready, accept, leaving;
    out_t  out_q;
    dec_t  dec;
    word_t rf_a, rf_b, opa, opb, imm_ext;

    reg_file_16x24 #(.NREGS(NREGS)) u_rf (
        .clk     (Clock),
        .rst     (Reset),
        .we      (WbEn),
        .waddr   (WbAddr),
        .wdata   (WbData),
        .raddr_a (Rs),
        .raddr_b (Rt),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    assign in_ready = ~out_valid | OutReady;
    assign accept   = InValid & in_ready;
    assign leaving  = out_valid & OutReady;
    assign imm_ext  = {{(WORD_W-IMM_W){Imm[IMM_W-1]}}, Imm};

    // The instruction leaving this cycle is younger than anything in WB, so it wins.
    function automatic word_t bypass(input logic [REG_AW-1:0] r, input word_t rf);
        if (r == '0)                      return '0;
        if (leaving && out_q.rd == r)     return ExResult;
        if (WbEn && WbAddr == r)          return WbData;
        return rf;
    endfunction

    always_comb begin
        dec = decode(FuncOp);
        opa = bypass(Rs, rf_a);
        opb = UseImm ? imm_ext : bypass(Rt, rf_b);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_valid  <= 1'b0;
            illegal_q  <= 1'b0;
            out_q.a    <= '0;
            out_q.b    <= '0;
            out_q.ainv <= 1'b0;
            out_q.bneg <= 1'b0;
            out_q.op   <= ALU_AND;
            out_q.rd   <= '0;
        end else begin
            illegal_q <= accept & ~dec.legal;
            if (accept) begin
                out_valid <= dec.legal;
                if (dec.legal) begin
                    out_q.a    <= opa;
                    out_q.b    <= opb;
                    out_q.ainv <= dec.ainv;
                    out_q.bneg <= dec.bneg;
                    out_q.op   <= dec.op;
                    out_q.rd   <= Rd;
                end
            end else if (OutReady) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign InReady   = in_ready;
    assign OutValid  = out_valid;
    assign IllegalOp = illegal_q;
    assign A         = out_q.a;
    assign B         = out_q.b;
    assign AInvert   = out_q.ainv;
    assign BNegate   = out_q.bneg;
    assign ALUOp     = out_q.op;
    assign OutRd     = out_q.rd;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected operand bundles are queued at
// acceptance and compared while held at the output, popped when consumed.
module tb_alu_operand_stage;
    typedef struct {
        logic        inv;
        logic [2:0]  fn;
        logic [3:0]  rs, rt, rd;
        logic [11:0] imm;
        logic        ui, ordy;
        logic [23:0] exres;
        logic        wben;
        logic [3:0]  wba;
        logic [23:0] wbd;
    } stim_t;

    typedef struct {
        logic [23:0] a, b;
        logic        ainv, bneg;
        logic [2:0]  op;
        logic [3:0]  rd;
    } exp_t;

    logic        Clock = 0, Reset = 1, InValid = 0, UseImm = 0, OutReady = 0, WbEn = 0;
    logic [2:0]  FuncOp = 0;
    logic [3:0]  Rs = 0, Rt = 0, Rd = 0, WbAddr = 0;
    logic [11:0] Imm = 0;
    logic [23:0] ExResult = 0, WbData = 0;
    logic        InReady, OutValid, AInvert, BNegate, IllegalOp;
    logic [23:0] A, B;
    logic [2:0]  ALUOp;
    logic [3:0]  OutRd;

    alu_operand_stage dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .FuncOp(FuncOp), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm), .UseImm(UseImm),
        .OutValid(OutValid), .OutReady(OutReady), .A(A), .B(B),
        .AInvert(AInvert), .BNegate(BNegate), .ALUOp(ALUOp), .OutRd(OutRd),
        .ExResult(ExResult), .WbEn(WbEn), .WbAddr(WbAddr), .WbData(WbData),
        .IllegalOp(IllegalOp)
    );

    always #5 Clock = ~Clock;

    int          n_total = 0, n_pass = 0;
    exp_t        q[$];
    logic [23:0] mreg [16];
    logic        exp_ill = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{inv: 0, fn: 0, rs: 0, rt: 0, rd: 0, imm: 0, ui: 0, ordy: 1,
              exres: 0, wben: 0, wba: 0, wbd: 0};
        return s;
    endfunction

    function automatic stim_t ins(input logic [2:0] fn, input logic [3:0] rs, rt, rd,
                                  input logic ui, input logic [11:0] imm);
        stim_t s;
        s = idle();
        s.inv = 1; s.fn = fn; s.rs = rs; s.rt = rt; s.rd = rd; s.ui = ui; s.imm = imm;
        return s;
    endfunction

    function automatic logic [23:0] src(input logic [3:0] r, input stim_t s,
                                        input logic lv, input logic [3:0] lrd);
        if (r == 0)                 return 24'h0;
        if (lv && lrd == r)         return s.exres;
        if (s.wben && s.wba == r)   return s.wbd;
        return mreg[r];
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        logic acc, lv, legal;
        logic [3:0] lrd;
        @(negedge Clock);
        InValid = s.inv; FuncOp = s.fn; Rs = s.rs; Rt = s.rt; Rd = s.rd; Imm = s.imm;
        UseImm = s.ui; OutReady = s.ordy; ExResult = s.exres;
        WbEn = s.wben; WbAddr = s.wba; WbData = s.wbd;
        #1;
        chk("out_valid", OutValid, q.size() != 0);
        chk("in_ready", InReady, q.size() == 0 || s.ordy);
        chk("illegal", IllegalOp, exp_ill);
        if (OutValid && q.size() != 0) begin
            chk("a", A, q[0].a);
            chk("b", B, q[0].b);
            chk("ainv", AInvert, q[0].ainv);
            chk("bneg", BNegate, q[0].bneg);
            chk("aluop", ALUOp, q[0].op);
            chk("rd", OutRd, q[0].rd);
        end
        acc = s.inv && (q.size() == 0 || s.ordy);
        lv  = q.size() != 0 && s.ordy;
        lrd = lv ? q[0].rd : 4'd0;
        legal = 1;
        e.ainv = 0; e.bneg = 0; e.op = 3'b000;
        case (s.fn)
            3'd0: e.op = 3'b010;
            3'd1: begin e.bneg = 1; e.op = 3'b010; end
            3'd2: e.op = 3'b000;
            3'd3: e.op = 3'b001;
            3'd4: begin e.ainv = 1; e.bneg = 1; e.op = 3'b000; end
            3'd5: begin e.bneg = 1; e.op = 3'b011; end
            default: legal = 0;
        endcase
        e.a  = src(s.rs, s, lv, lrd);
        e.b  = s.ui ? {{12{s.imm[11]}}, s.imm} : src(s.rt, s, lv, lrd);
        e.rd = s.rd;
        if (lv) void'(q.pop_front());
        if (acc && legal) q.push_back(e);
        exp_ill = acc && !legal;
        if (s.wben && s.wba != 0) mreg[s.wba] = s.wbd;
        @(posedge Clock);
    endtask

    // Reset asserted with a live instruction, a stall and a write all pending.
    task automatic do_reset();
        @(negedge Clock);
        Reset = 1; InValid = 1; FuncOp = 0; Rs = 5; OutReady = 0;
        WbEn = 1; WbAddr = 6; WbData = 24'h666666;
        @(posedge Clock);
        q.delete();
        for (int i = 0; i < 16; i++) mreg[i] = 24'h0;
        exp_ill = 0;
        @(negedge Clock);
        Reset = 0; InValid = 0; WbEn = 0;
        #1;
        chk("rst_valid", OutValid, 1'b0);
        chk("rst_ready", InReady, 1'b1);
        chk("rst_ill", IllegalOp, 1'b0);
        chk("rst_a", A, 24'h0);
        chk("rst_b", B, 24'h0);
        chk("rst_op", ALUOp, 3'b000);
        chk("rst_rd", OutRd, 4'h0);
        chk("rst_flags", {AInvert, BNegate}, 2'b00);
    endtask

    initial begin
        stim_t s;
        for (int i = 0; i < 16; i++) mreg[i] = 24'h0;
        repeat (2) @(posedge Clock);
        do_reset();

        // Reset mid-stall: R5 written, ADD held, then reset clears everything.
        s = idle(); s.wben = 1; s.wba = 5; s.wbd = 24'h555555; step(s);
        s = ins(0, 5, 0, 1, 0, 0); step(s);
        s = idle(); s.ordy = 0; step(s);
        do_reset();
        s = ins(0, 5, 6, 2, 0, 0); step(s);
        #1 chk("r5_after_rst", A, 24'h0);
        chk("r6_rst_dominates", B, 24'h0);

        // SUB with sign-extended immediate.
        s = idle(); s.wben = 1; s.wba = 3; s.wbd = 24'h000010; step(s);
        s = ins(1, 3, 9, 2, 1, 12'hFFF); step(s);
        #1 chk("sub_a", A, 24'h000010);
        chk("sub_b", B, 24'hFFFFFF);
        chk("sub_bneg_op", {BNegate, ALUOp}, {1'b1, 3'b010});
        step(idle());

        // Back-to-back: Ex forward beats same-cycle writeback.
        s = ins(0, 1, 2, 4, 0, 0); step(s);
        s = ins(3, 4, 4, 5, 0, 0); s.exres = 24'h123456;
        s.wben = 1; s.wba = 4; s.wbd = 24'hAAAAAA; step(s);
        #1 chk("fwd_a", A, 24'h123456);
        chk("fwd_b", B, 24'h123456);
        step(idle());

        // Write-through from the WB port.
        s = ins(2, 7, 0, 3, 0, 0); s.wben = 1; s.wba = 7; s.wbd = 24'h800000; step(s);
        #1 chk("wt_a", A, 24'h800000);
        step(idle());

        // Backpressure: three stalled cycles, second instruction follows the release.
        s = ins(0, 4, 7, 8, 0, 0); step(s);
        s = ins(3, 7, 4, 9, 0, 0); s.ordy = 0;
        repeat (3) step(s);
        s.ordy = 1; step(s);
        #1 chk("bp_second_rd", OutRd, 4'd9);
        step(idle());

        // Illegal opcode, then R0 write is ignored and NOR decode.
        s = ins(7, 1, 2, 3, 0, 0); step(s);
        #1 chk("ill_pulse", IllegalOp, 1'b1);
        chk("ill_novalid", OutValid, 1'b0);
        step(idle());
        #1 chk("ill_one_cycle", IllegalOp, 1'b0);
        s = idle(); s.wben = 1; s.wba = 0; s.wbd = 24'hFFFFFF; step(s);
        s = ins(4, 0, 0, 6, 0, 0); step(s);
        #1 chk("r0_zero", A, 24'h0);
        chk("nor_flags", {AInvert, BNegate}, 2'b11);
        step(idle());

        // Random traffic with stalls, bypasses and illegal codes.
        for (int i = 0; i < 400; i++) begin
            s = ins(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom), 12'($urandom));
            s.inv   = ($urandom_range(0, 3) != 0);
            s.ordy  = ($urandom_range(0, 9) < 7);
            s.exres = 24'($urandom);
            s.wben  = 1'($urandom);
            s.wba   = 4'($urandom);
            s.wbd   = 24'($urandom);
            step(s);
        end
        repeat (3) step(idle());
        chk("drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
